instr_fetch_stage: RTL and testbench

//  Fetch stage between PC and decode. Drives the fetch address into the 16x32 instruction memory.

---
 rtl/instr_fetch_stage.sv | 126 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Fetch stage: drives the instruction-memory address and buffers {pc, word} bundles in a 2-entry FIFO toward decode.
// Optional performance counters (stall_cnt, flush_cnt) are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd2,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_pc,
    output logic        mem_read,
    input  logic [31:0] ir_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [15:0] out_slot0,
    output logic [15:0] out_slot1
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    localparam logic [1:0] QMAX = 2'(QDEPTH);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      e0_q, e0_d;
    entry_t      e1_q, e1_d;
    logic [1:0]  wr_pos;
    logic        deq;
    logic        room;
    logic        enq;

    assign fetch_pc  = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign deq       = out_valid & out_ready;
    assign room      = (count_q < QMAX) | deq;
    assign enq       = ~redirect_valid & room;
    assign mem_read  = reset & enq;

    // out_pc deliberately keeps the last head PC once the queue drains; only the slots fall back to nop.
    assign out_pc    = e0_q.pc;
    assign out_slot0 = out_valid ? e0_q.ir[31:16] : 16'h0000;
    assign out_slot1 = out_valid ? e0_q.ir[15:0]  : 16'h0000;

    // Position the new bundle lands in once this cycle's dequeue has shifted the queue.
    assign wr_pos = count_q - {1'b0, deq};

    // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else if (room) begin
            pc_d    = pc_q + PC_STEP;
            count_d = count_q + 2'd1 - {1'b0, deq};
            if (deq) begin
                e0_d = e1_q;
            end
            if (wr_pos == 2'd0) begin
                e0_d = '{pc: pc_q, ir: ir_in};
            end else begin
                e1_d = '{pc: pc_q, ir: ir_in};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; the queue storage is reset too so out_pc reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        // A flush only counts when it actually discards buffered bundles.
        if (redirect_valid && count_q != 2'd0 && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: fill, stall, redirects, PC wrap and asynchronous reset.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        mem_read;
    logic [31:0] ir_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [15:0] out_slot0;
    logic [15:0] out_slot1;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ir_in = mem[fetch_pc[4:1]];

    instr_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .mem_read       (mem_read),
        .ir_in          (ir_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_slot0      (out_slot0),
        .out_slot1      (out_slot1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc: got %h expected 00000000", out_pc); end
        checks++; if ({out_slot0, out_slot1} !== 32'h0) begin errors++; $display("FAIL rst_slots: got %h expected 00000000", {out_slot0, out_slot1}); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_fetch_pc: got %h expected 00000000", fetch_pc); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
    endtask

    task automatic test_fill();
        step();
        reset = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL fill_mem_read: got %b expected 1", mem_read); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid0: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL fill_pc0: got %h expected 00000000", out_pc); end
        checks++; if ({out_slot0, out_slot1} !== 32'h0) begin errors++; $display("FAIL fill_slots0: got %h expected 00000000", {out_slot0, out_slot1}); end
        checks++; if (fetch_pc !== 32'h2) begin errors++; $display("FAIL fill_fetch2: got %h expected 00000002", fetch_pc); end
        step();
        checks++; if (out_pc !== 32'h2) begin errors++; $display("FAIL fill_pc2: got %h expected 00000002", out_pc); end
        checks++; if (out_slot0 !== 16'h2001) begin errors++; $display("FAIL fill_slot0_w1: got %h expected 2001", out_slot0); end
        checks++; if (out_slot1 !== 16'h0000) begin errors++; $display("FAIL fill_slot1_w1: got %h expected 0000", out_slot1); end
        checks++; if (fetch_pc !== 32'h4) begin errors++; $display("FAIL fill_fetch4: got %h expected 00000004", fetch_pc); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        out_ready = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        checks++; if (fetch_pc !== 32'h2) begin errors++; $display("FAIL stall_fetch2: got %h expected 00000002", fetch_pc); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (fetch_pc !== 32'h4) begin errors++; $display("FAIL stall_fetch_hold: got %h expected 00000004", fetch_pc); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL stall_mem_read: got %b expected 0", mem_read); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL stall_head: got %h expected 00000000", out_pc); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", stall_cnt); end
`endif
        out_ready = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL stall_full_deq_read: got %b expected 1", mem_read); end
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(2 * i);
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin errors++; $display("FAIL stall_drain%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, exp_pc); end
            step();
        end
        checks++; if (fetch_pc !== 32'ha) begin errors++; $display("FAIL stall_fetch_after: got %h expected 0000000a", fetch_pc); end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h12;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL redir_mem_read: got %b expected 0", mem_read); end
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", out_valid); end
        checks++; if (fetch_pc !== 32'h12) begin errors++; $display("FAIL redir_fetch: got %h expected 00000012", fetch_pc); end
        checks++; if ({out_slot0, out_slot1} !== 32'h0) begin errors++; $display("FAIL redir_nop: got %h expected 00000000", {out_slot0, out_slot1}); end
        checks++; if (out_pc !== 32'h6) begin errors++; $display("FAIL redir_out_pc_keep: got %h expected 00000006", out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h12) begin errors++; $display("FAIL redir_target: got valid=%b pc=%h expected valid=1 pc=00000012", out_valid, out_pc); end
        checks++; if (out_slot0 !== 16'h20ff || out_slot1 !== 16'h0000) begin errors++; $display("FAIL redir_word9: got %h%h expected 20ff0000", out_slot0, out_slot1); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got %0d expected 1", flush_cnt); end
`endif
    endtask

    task automatic test_redirect_deq();
        redirect_valid = 1'b1; redirect_pc = 32'h2;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || fetch_pc !== 32'h2) begin errors++; $display("FAIL rdeq_flush: got valid=%b fetch=%h expected valid=0 fetch=00000002", out_valid, fetch_pc); end
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rdeq_mem_read: got %b expected 1", mem_read); end
        step();
        checks++; if (out_pc !== 32'h2 || out_slot0 !== 16'h2001) begin errors++; $display("FAIL rdeq_first: got pc=%h slot0=%h expected pc=00000002 slot0=2001", out_pc, out_slot0); end
        step();
        checks++; if (out_pc !== 32'h4 || out_slot0 !== 16'h1002) begin errors++; $display("FAIL rdeq_second: got pc=%h slot0=%h expected pc=00000004 slot0=1002", out_pc, out_slot0); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffe;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_pc !== 32'hffff_fffe) begin errors++; $display("FAIL wrap_fetch: got %h expected fffffffe", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap_fetch0: got %h expected 00000000", fetch_pc); end
        checks++; if (out_pc !== 32'hffff_fffe || {out_slot0, out_slot1} !== 32'h100f_500f) begin errors++; $display("FAIL wrap_head: got pc=%h word=%h expected pc=fffffffe word=100f500f", out_pc, {out_slot0, out_slot1}); end
        step();
        checks++; if (out_pc !== 32'h0 || out_slot0 !== 16'h0000 || fetch_pc !== 32'h2) begin errors++; $display("FAIL wrap_next: got pc=%h slot0=%h fetch=%h expected pc=00000000 slot0=0000 fetch=00000002", out_pc, out_slot0, fetch_pc); end
    endtask

    task automatic test_async_reset();
        step();
        out_ready = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2) begin errors++; $display("FAIL arst_pre: got valid=%b pc=%h expected valid=1 pc=00000002", out_valid, out_pc); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || {out_slot0, out_slot1} !== 32'h0) begin errors++; $display("FAIL arst_immediate: got valid=%b slots=%h expected valid=0 slots=00000000", out_valid, {out_slot0, out_slot1}); end
        checks++; if (out_pc !== 32'h0 || fetch_pc !== 32'h0 || mem_read !== 1'b0) begin errors++; $display("FAIL arst_state: got out_pc=%h fetch=%h rd=%b expected 00000000 00000000 0", out_pc, fetch_pc, mem_read); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_held: got %b expected 0", out_valid); end
        reset = 1'b1;
        #1;
        checks++; if (fetch_pc !== 32'h0 || mem_read !== 1'b1) begin errors++; $display("FAIL arst_release: got fetch=%h rd=%b expected 00000000 1", fetch_pc, mem_read); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL arst_first: got valid=%b pc=%h expected valid=1 pc=00000000", out_valid, out_pc); end
        step();
        checks++; if (out_pc !== 32'h2 || out_slot0 !== 16'h2001) begin errors++; $display("FAIL arst_second: got pc=%h slot0=%h expected pc=00000002 slot0=2001", out_pc, out_slot0); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {16'h1000 + 16'(i), 16'h5000 + 16'(i)};
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h2001_0000;
        mem[9] = 32'h20ff_0000;
        test_reset();
        test_fill();
        test_stall();
        test_redirect_full();
        test_redirect_deq();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within 20000 time units");
        $fatal(1);
    end

endmodule
